// File: rtl/imem_port_arbiter_if.sv
// Handshake/bus bundle between the fetch unit, the load/store port, the shared
// single-port memory and the arbiter that multiplexes them.
interface imem_port_arbiter_if #(
    parameter int ADDR = 16,
    parameter int WORD = 32
);
    logic            if_req_i;
    logic [ADDR-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [WORD-1:0] if_rdata_o;

    logic            d_req_i;
    logic            d_we_i;
    logic [ADDR-1:0] d_addr_i;
    logic [WORD-1:0] d_wdata_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [WORD-1:0] d_rdata_o;

    logic [ADDR-1:0] mem_a_o;
    logic            mem_w_o;
    logic [WORD-1:0] mem_d_o;
    logic [WORD-1:0] mem_q_i;

    logic            stall_if_o;

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_a_o, mem_w_o, mem_d_o, stall_if_o
    );

    // Requester and memory side.
    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_a_o, mem_w_o, mem_d_o, stall_if_o
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction/data memory between fetch (read-only)
// and load/store (read/write); routes the one-cycle-late Q to the read's owner.
//
// rsp_owner | meaning
// ----------+-------------------------------------------------------------
// RSP_NONE  | no read issued last cycle; neither rvalid asserted
// RSP_IF    | fetch read granted last cycle; mem_q_i belongs to fetch
// RSP_D     | data read granted last cycle; mem_q_i belongs to load/store
module imem_port_arbiter #(
    parameter int ADDR       = 16,
    parameter int WORD       = 32,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_t;

    typedef enum logic {
        GRANT_IF   = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rsp_t       rsp_owner;
    grant_t     last_grant;
    logic [3:0] starve_cnt;

    logic fetch_wins;
    logic if_gnt;
    logic d_gnt;

    always_comb begin
        fetch_wins = 1'b0;
        if (bus.if_req_i && !bus.d_req_i) begin
            fetch_wins = 1'b1;
        end else if (bus.if_req_i && bus.d_req_i) begin
            if (ARB_MODE == 1) begin
                fetch_wins = (last_grant == GRANT_DATA);
            end else begin
                fetch_wins = (starve_cnt == STARVE_LIM);
            end
        end
    end

    assign if_gnt = fetch_wins;
    assign d_gnt  = bus.d_req_i & ~fetch_wins;

    assign bus.if_gnt_o   = if_gnt;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.stall_if_o = bus.if_req_i & ~if_gnt;

    // Memory pins are driven straight from the grant so the access lands on this edge.
    assign bus.mem_a_o = if_gnt ? bus.if_addr_i :
                         d_gnt  ? bus.d_addr_i  : {ADDR{1'b0}};
    assign bus.mem_w_o = d_gnt & bus.d_we_i;
    assign bus.mem_d_o = d_gnt ? bus.d_wdata_i : {WORD{1'b0}};

    assign bus.if_rdata_o  = bus.mem_q_i;
    assign bus.d_rdata_o   = bus.mem_q_i;
    assign bus.if_rvalid_o = (rsp_owner == RSP_IF);
    assign bus.d_rvalid_o  = (rsp_owner == RSP_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_owner  <= RSP_NONE;
            last_grant <= GRANT_DATA;
            starve_cnt <= 4'd0;
        end else begin
            if (if_gnt) begin
                rsp_owner <= RSP_IF;
            end else if (d_gnt && !bus.d_we_i) begin
                rsp_owner <= RSP_D;
            end else begin
                rsp_owner <= RSP_NONE;
            end

            if (if_gnt) begin
                last_grant <= GRANT_IF;
            end else if (d_gnt) begin
                last_grant <= GRANT_DATA;
            end

            // Saturates so fetch keeps winning until it is actually served.
            if (!bus.if_req_i || if_gnt) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port 32x64k instruction/data memory between the instruction fetch unit (read-only) and the data load/store port (read/write).
- Sits between the fetch/LSU pipelines and the memory instance, and drives the memory's A/W/D pins.
- Makes a per-cycle grant decision and tracks the one-cycle read latency to route Q to the correct requester.
- Includes a starvation guard so fetch makes progress under sustained data traffic.

Parameters:
- ADDR, 16, address width (memory depth 2^ADDR words)
- WORD, 32, data width
- ARB_MODE, 0, 0 = data-priority with starvation guard; 1 = strict alternating round-robin
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins (ARB_MODE 0 only); legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  WORD  fetch read data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR  data address
- d_wdata_i  in  WORD  write data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data read data valid
- d_rdata_o  out  WORD  data read data
- mem_a_o  out  ADDR  memory address
- mem_w_o  out  1  memory write enable
- mem_d_o  out  WORD  memory write data
- mem_q_i  in  WORD  memory read data, valid one cycle after the address
- stall_if_o  out  1  equals if_req_i & ~if_gnt_o; drives the fetch stall input

Behaviour:
- Reset (rst=0, asynchronous): if_rvalid_o=0, d_rvalid_o=0, starve_cnt=0, rsp_owner=NONE, last_grant=DATA. The grant outputs and mem_* outputs are combinational and read 0 when no request is present.
- Grant logic is combinational from the requests and registered state. At most one grant per cycle.
- If only one requester is active, it is granted.
- Both active, ARB_MODE 0:
  - Data is granted unless starve_cnt == STARVE_MAX, in which case fetch is granted.
- Both active, ARB_MODE 1:
  - Grant goes to the requester opposite last_grant.
  - last_grant updates on every grant.
- Memory drive:
  - Fetch granted: mem_a_o=if_addr_i, mem_w_o=0.
  - Data granted: mem_a_o=d_addr_i, mem_w_o=d_we_i, mem_d_o=d_wdata_i.
  - No grant: mem_a_o=0, mem_w_o=0, mem_d_o=0.
- starve_cnt (4 bits, saturating at STARVE_MAX):
  - Increments when if_req_i=1 and if_gnt_o=0.
  - Clears when fetch is granted or if_req_i=0.
- Response FSM, register rsp_owner ∈ {NONE, IF, D}:
  - Next state = IF on a fetch grant, D on a data read grant, otherwise NONE. Data writes yield NONE.
  - if_rvalid_o = (rsp_owner==IF); d_rvalid_o = (rsp_owner==D).
  - Read latency is exactly 1 cycle from grant to rvalid.
- if_rdata_o and d_rdata_o both equal mem_q_i; each is meaningful only while its rvalid is high.
- Writes: take effect at the grant edge, no rvalid is produced, and a fully pipelined write-then-read to the same address returns new data.
- Back-to-back grants are fully pipelined: a new grant may issue in the same cycle as the previous rvalid.
- Requesters hold req/addr/wdata stable until granted; a request dropped before grant is simply not served.
- Reset asserted mid-operation: a read granted in the cycle before reset produces no rvalid, and the counter clears.

Test Plan:
- Fetch only: if_req_i=1 for 5 cycles at addresses 0x0000..0x0004 -> if_gnt_o=1 every cycle; if_rvalid_o=1 in cycles 2..6 with data of addresses 0..4; d_rvalid_o never asserts.
- Data write then read: write 0xDEADBEEF to 0x1234, then read 0x1234 next cycle -> mem_w_o=1 for exactly 1 cycle; d_rvalid_o=1 one cycle after the read grant with d_rdata_o=0xDEADBEEF; no rvalid for the write.
- Starvation, ARB_MODE 0 with STARVE_MAX=4, both requests held high -> data granted 4 cycles, fetch granted in the 5th, and the pattern repeats; stall_if_o=1 on exactly the denied cycles.
- Round-robin, ARB_MODE 1, both requests held high with last_grant=DATA after reset -> grants alternate IF, D, IF, D; each rvalid is routed to the matching owner one cycle later.
- Async reset: deassert rst in the same cycle a fetch read is granted -> if_rvalid_o stays 0 the following cycle; starve_cnt=0; the first grant after release follows the reset priority.
- Data read, data write, fetch interleaving with d_we_i toggling every cycle -> no rvalid is ever produced for writes, and no cycle has both rvalids high.
